// File: rtl/ser_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg
// Shared types and constants for the 8-bit word serializer.
//   WORD_W  : width of the parallel word
//   CNT_W   : width of the bit counter / mux select
//   state_e : serializer FSM states (PAR is only reachable when the
//             WORD_SERIALIZER_PARITY_EN macro is defined)
// ----------------------------------------------------------------------------
package ser_pkg;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

endpackage

// File: rtl/mux8to1.sv
// ----------------------------------------------------------------------------
// mux8to1
// Combinational 8:1 bit-select mux.
//   in_i  : 8-bit parallel word
//   sel_i : 3-bit index of the bit to present
//   y_o   : selected bit, in_i[sel_i]
// ----------------------------------------------------------------------------
module mux8to1
    import ser_pkg::*;
(
    input  logic [WORD_W-1:0] in_i,
    input  logic [CNT_W-1:0]  sel_i,
    output logic              y_o
);

    assign y_o = in_i[sel_i];

endmodule

// File: rtl/word_serializer_8b.sv
// ----------------------------------------------------------------------------
// word_serializer_8b
// Parallel-to-serial converter: accepts 8-bit words over valid/ready and
// emits one bit per accepted beat, with downstream backpressure. The word is
// held in a register and the bit is picked by the mux8to1 sub-module.
//
// Parameters:
//   LSB_FIRST  : 1 -> select sequence 0..7, 0 -> select sequence 7..0
//   IDLE_LEVEL : level on ser_out while ser_valid is low
// Optional feature:
//   WORD_SERIALIZER_PARITY_EN : when defined, a ninth beat carrying even
//                               parity of the word follows the data beats
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : parallel word input and its valid
//   in_ready            : a word can be accepted this cycle
//   ser_out/ser_valid   : serial bit and its valid
//   ser_ready           : downstream accepts the current bit
//   sel                 : current mux select
//   busy                : a word is in flight
//   done                : one-cycle pulse after the final beat of a word
// ----------------------------------------------------------------------------
module word_serializer_8b
    import ser_pkg::*;
#(
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic [CNT_W-1:0]  sel,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               muxBit;
    logic               lastBeat;
    logic               finalAccept;
    logic               beatAccept;
    logic               load;

    mux8to1 u_mux (
        .in_i  (hold_q),
        .sel_i (sel),
        .y_o   (muxBit)
    );

    // The final beat of a word is the parity beat when parity is built in,
    // otherwise the eighth data beat.
`ifdef WORD_SERIALIZER_PARITY_EN
    assign lastBeat = (state_q == PAR);
`else
    assign lastBeat = (state_q == DATA) && (cnt_q == CNT_W'(7));
`endif

    assign beatAccept  = ser_valid && ser_ready;
    assign finalAccept = lastBeat && ser_ready;

    // A new word may be taken when idle, or in the final beat while it is
    // being accepted so consecutive words run without a bubble.
    assign in_ready = !rst && ((state_q == IDLE) || finalAccept);
    assign load     = in_valid && in_ready;

    assign ser_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // Select and serial bit depend only on registered state. In PAR the
    // counter stays at 7, so sel keeps showing the last data index.
    always_comb begin
        sel     = '0;
        ser_out = IDLE_LEVEL;
        case (state_q)
            DATA: begin
                sel     = LSB_FIRST ? cnt_q : (CNT_W'(7) - cnt_q);
                ser_out = muxBit;
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            PAR: begin
                sel     = LSB_FIRST ? cnt_q : (CNT_W'(7) - cnt_q);
                ser_out = ^hold_q;
            end
`endif
            default: begin
                sel     = '0;
                ser_out = IDLE_LEVEL;
            end
        endcase
    end

    // Next-state logic: advance on accepted beats, then let a load
    // override whatever the current word would have done next.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            DATA: begin
                if (beatAccept) begin
                    if (cnt_q == CNT_W'(7)) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                        state_d = PAR;
`else
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            PAR: begin
                if (beatAccept) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            hold_d  = in_data;
            cnt_d   = '0;
            state_d = DATA;
        end
    end

    // State register with synchronous reset; a reset mid-word drops the
    // word and suppresses its done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_word_serializer_8b.sv
// ----------------------------------------------------------------------------
// tb_word_serializer_8b
// Scoreboard bench: two serializers (LSB-first and MSB-first) share the same
// stimulus. Each accepted word pushes its expected beats onto a queue; each
// accepted serial beat pops one. Handshake, valid, busy and done are checked
// every cycle against a small model driven from the queue.
// ----------------------------------------------------------------------------
module tb_word_serializer_8b;
    import ser_pkg::*;

    typedef struct {
        logic       bitL;
        logic       bitM;
        logic [2:0] selL;
        logic [2:0] selM;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_ready;

    logic       inReadyL, serOutL, serValidL, busyL, doneL;
    logic [2:0] selL;
    logic       inReadyM, serOutM, serValidM, busyM, doneM;
    logic [2:0] selM;

    beat_t      sb[$];
    logic       expDone = 1'b0;
    int         errors  = 0;
    int         checks  = 0;

    always #5 clk = ~clk;

    word_serializer_8b #(.LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dutLsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(inReadyL), .ser_out(serOutL), .ser_valid(serValidL),
        .ser_ready(ser_ready), .sel(selL), .busy(busyL), .done(doneL)
    );

    word_serializer_8b #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dutMsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(inReadyM), .ser_out(serOutM), .ser_valid(serValidM),
        .ser_ready(ser_ready), .sel(selM), .busy(busyM), .done(doneM)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected beat sequence for one word, in both bit orders.
    task automatic pushWord(input logic [7:0] w);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.bitL = w[i];
            b.bitM = w[7-i];
            b.selL = 3'(i);
            b.selM = 3'(7 - i);
`ifdef WORD_SERIALIZER_PARITY_EN
            b.last = 1'b0;
`else
            b.last = (i == 7);
`endif
            sb.push_back(b);
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        b.bitL = ^w;
        b.bitM = ^w;
        b.selL = 3'd7;
        b.selM = 3'd0;
        b.last = 1'b1;
        sb.push_back(b);
`endif
    endtask

    // Monitor: compare at the falling edge, then advance the model to what
    // the next rising edge should do.
    always @(negedge clk) begin
        logic  expValid;
        logic  expReady;
        logic  nextDone;
        beat_t e;
        expValid = (sb.size() != 0);
        expReady = !rst && ((sb.size() == 0) || ((sb.size() == 1) && ser_ready));
        checkOutput("in_ready_lsb", {7'd0, inReadyL}, {7'd0, expReady});
        checkOutput("in_ready_msb", {7'd0, inReadyM}, {7'd0, expReady});
        checkOutput("ser_valid_lsb", {7'd0, serValidL}, {7'd0, expValid});
        checkOutput("ser_valid_msb", {7'd0, serValidM}, {7'd0, expValid});
        checkOutput("busy_lsb", {7'd0, busyL}, {7'd0, expValid});
        checkOutput("busy_msb", {7'd0, busyM}, {7'd0, expValid});
        checkOutput("done_lsb", {7'd0, doneL}, {7'd0, expDone});
        checkOutput("done_msb", {7'd0, doneM}, {7'd0, expDone});
        if (expValid) begin
            checkOutput("ser_out_lsb", {7'd0, serOutL}, {7'd0, sb[0].bitL});
            checkOutput("ser_out_msb", {7'd0, serOutM}, {7'd0, sb[0].bitM});
            checkOutput("sel_lsb", {5'd0, selL}, {5'd0, sb[0].selL});
            checkOutput("sel_msb", {5'd0, selM}, {5'd0, sb[0].selM});
        end else begin
            checkOutput("idle_out_lsb", {7'd0, serOutL}, 8'd1);
            checkOutput("idle_out_msb", {7'd0, serOutM}, 8'd1);
            checkOutput("idle_sel_lsb", {5'd0, selL}, 8'd0);
            checkOutput("idle_sel_msb", {5'd0, selM}, 8'd0);
        end
        nextDone = 1'b0;
        if (rst) begin
            sb.delete();
        end else begin
            if (expValid && ser_ready) begin
                e = sb.pop_front();
                nextDone = e.last;
            end
            if (in_valid && expReady) pushWord(in_data);
        end
        expDone = nextDone;
    end

    // Present one word and hold it until the handshake completes.
    task automatic applyStimulus(input logic [7:0] w);
        bit accepted = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (inReadyL) accepted = 1'b1;
        end
        if (!accepted) checkOutput("accept_timeout", 8'd0, 8'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until the serializer drains, then let any done pulse be seen.
    task automatic waitIdle();
        bit idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            if (!busyL && sb.size() == 0) idle = 1'b1;
        end
        if (!idle) checkOutput("idle_timeout", 8'd0, 8'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single words in both bit orders
        applyStimulus(8'hA5);
        waitIdle();
        applyStimulus(8'h81);
        waitIdle();

        // Downstream stall of three cycles while beat 2 is presented
        applyStimulus(8'h3C);
        repeat (2) @(posedge clk);
        #1;
        ser_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ser_ready = 1'b1;
        waitIdle();

        // Back-to-back words with in_valid held
        applyStimulus(8'hFF);
        applyStimulus(8'h00);
        waitIdle();

        // Reset in the middle of a word, then a fresh word
        applyStimulus(8'h5A);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(8'h01);
        waitIdle();

        // Parity-sensitive words (odd and even weight)
        applyStimulus(8'h07);
        waitIdle();
        applyStimulus(8'h03);
        waitIdle();

        // Stall landing on the final beat while a next word waits
        applyStimulus(8'hC3);
        repeat (7) @(posedge clk);
        #1;
        ser_ready = 1'b0;
        in_data   = 8'h96;
        in_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ser_ready = 1'b1;
        in_valid  = 1'b0;
        applyStimulus(8'h96);
        waitIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
